// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine producing MIPS-style HI/LO results.
// One bit per cycle. Signed operations run on operand magnitudes, and the
// signs are applied in a single fix-up cycle before HI/LO are written.
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | ITER shift-add / restoring-divide iterations
// FIX   | apply signs, write hi/lo
// DONE  | one-cycle done pulse; a new start may be accepted here
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_step, prod;
  logic [WIDTH-1:0]     op_b, mag1, mag2, quot, rem, fix_hi, fix_lo;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 op_div, op_signed, sign_a, sign_b;
  logic                 accept, in2_zero;

  assign in2_zero = (in2 == '0);
  assign accept   = start && (control[3:2] == 2'b11) && ((state == IDLE) || (state == DONE));
  assign mag1     = (control[1] && in1[WIDTH-1]) ? -in1 : in1;
  assign mag2     = (control[1] && in2[WIDTH-1]) ? -in2 : in2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a divide by zero skips straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (control[0] && in2_zero) ? DONE : CALC;
        else        state_next = IDLE;
      end
      CALC:    if (cnt == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // One iteration step: acc holds {hi_part, multiplier} or {rem, quot}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, op_b};
    if (op_div) begin
      if (div_diff[WIDTH]) acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up; the remainder follows the dividend's sign
  always_comb begin
    prod   = (op_signed && (sign_a ^ sign_b)) ? -acc : acc;
    quot   = (op_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = (op_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = op_div ? rem  : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_div ? quot : prod[WIDTH-1:0];
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      op_b        <= '0;
      op_div      <= 1'b0;
      op_signed   <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      op_div      <= control[0];
      op_signed   <= control[1];
      sign_a      <= in1[WIDTH-1];
      sign_b      <= in2[WIDTH-1];
      op_b        <= control[0] ? mag2 : mag1;
      acc         <= {{WIDTH{1'b0}}, (control[0] ? mag1 : mag2)};
      div_by_zero <= control[0] && in2_zero;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_step;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

endmodule
